// File: rtl/data_cache_ctrl.sv
// data_cache_ctrl: direct-mapped, write-through, no-write-allocate data cache with line refill.
module data_cache_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int SETS = 4,
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_valid,
  input  logic                  cpu_we,
  input  logic                  cpu_byte,
  input  logic [DATA_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);
  localparam int IB = $clog2(SETS);
  localparam int OB = $clog2(WORDS);
  localparam int TB = DATA_WIDTH - IB - OB - 2;
  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;
  state_t state, state_nxt;
  logic [OB-1:0] beat;
  logic [SETS-1:0] valid;
  logic pend;
  logic [TB-1:0] tag_store [SETS];
  logic [DATA_WIDTH-1:0] data [SETS][WORDS];
  logic [TB-1:0] tag;
  logic [IB-1:0] set;
  logic [OB-1:0] word;
  logic [1:0] lane;
  logic hit, last, done, clear_all, hit_inc, miss_inc;
  logic [DATA_WIDTH-1:0] word_data, wdata_bus, merged;
  logic [7:0] byte_data;
  logic [3:0] strb;
  assign tag       = cpu_addr[DATA_WIDTH-1 -: TB];
  assign set       = cpu_addr[IB+OB+1 -: IB];
  assign word      = cpu_addr[OB+1:2];
  assign lane      = cpu_addr[1:0];
  assign hit       = cpu_valid & valid[set] & (tag_store[set] == tag);
  assign word_data = data[set][word];
  assign byte_data = word_data[{lane, 3'b000} +: 8];
  assign wdata_bus = cpu_byte ? {(DATA_WIDTH/8){cpu_wdata[7:0]}} : cpu_wdata;
  assign strb      = cpu_byte ? 4'b0001 << lane : 4'b1111;
  assign last      = mem_ack & (beat == OB'(WORDS - 1));
  assign done      = (state == FILL & last) | (state == WRITE & mem_ack);
  // A flush raised mid-transaction waits for the return to IDLE so the fill update cannot revalidate a line.
  assign clear_all = (state == IDLE & flush) | (done & (pend | flush));
  assign hit_inc   = (state == IDLE & cpu_valid & ~cpu_we & hit) | (state == WRITE & mem_ack & hit);
  assign miss_inc  = state == IDLE & cpu_valid & ~cpu_we & ~hit;
  always_comb begin
    merged = word_data;
    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = strb[i] ? wdata_bus[8*i +: 8] : word_data[8*i +: 8];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (state == IDLE)
      state_nxt = (cpu_valid & cpu_we) ? WRITE : (cpu_valid & ~hit) ? FILL : IDLE;
    else if (done)
      state_nxt = IDLE;
  end
  always_comb begin
    cpu_rdata = cpu_byte ? {{(DATA_WIDTH-8){1'b0}}, byte_data} : word_data;
    cpu_stall = rst_n & ((state == FILL) | (state == WRITE & ~mem_ack) |
                         (state == IDLE & cpu_valid & (cpu_we | ~hit)));
    mem_req   = state == FILL | state == WRITE;
    mem_we    = state == WRITE;
    mem_addr  = (state == FILL) ? {cpu_addr[DATA_WIDTH-1:OB+2], beat, 2'b00} :
                (state == WRITE) ? {cpu_addr[DATA_WIDTH-1:2], 2'b00} : '0;
    mem_wdata = (state == WRITE) ? wdata_bus : '0;
    mem_wstrb = (state == WRITE) ? strb : 4'b0000;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      beat       <= '0;
      valid      <= '0;
      pend       <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      beat       <= (state == FILL) ? beat + OB'(mem_ack) : '0;
      pend       <= done ? 1'b0 : (state != IDLE & flush) ? 1'b1 : pend;
      hit_count  <= hit_count + 32'(hit_inc & ~&hit_count);
      miss_count <= miss_count + 32'(miss_inc & ~&miss_count);
      if (clear_all) valid <= '0;
      else if (state == FILL & last) valid[set] <= 1'b1;
    end
  always_ff @(posedge clk) begin
    if (state == FILL & mem_ack) data[set][beat] <= mem_rdata;
    if (state == FILL & last) tag_store[set] <= tag;
    if (state == WRITE & mem_ack & hit) data[set][word] <= merged;
  end
endmodule

// File: doc/data_cache_ctrl.md
DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, 32, address and data width in bits.
REQ-002 Parameter SETS, 4, number of direct-mapped lines; power of two, at least 2.
REQ-003 Parameter WORDS, 4, words per line; power of two, at least 2.
REQ-004 Derived widths SHALL be: IB=log2(SETS), OB=log2(WORDS), TB=DATA_WIDTH-IB-OB-2.
REQ-005 Port clk, in, 1, single clock; all state is updated on its rising edge.
REQ-006 Port rst_n, in, 1, asynchronous, active-low reset.
REQ-007 Port cpu_valid, in, 1, access request.
REQ-008 Port cpu_we, in, 1, 1=store, 0=load.
REQ-009 Port cpu_byte, in, 1, 1=byte access, 0=word access.
REQ-010 Port cpu_addr, in, DATA_WIDTH, byte address; fields are tag[31:IB+OB+2], set[IB+OB+1:OB+2], word[OB+1:2], byte[1:0].
REQ-011 Port cpu_wdata, in, DATA_WIDTH, store data; a byte store uses bits [7:0].
REQ-012 Port flush, in, 1, one-cycle pulse that invalidates all lines.
REQ-013 Port cpu_rdata, out, DATA_WIDTH, load data; byte loads are zero-extended.
REQ-014 Port cpu_stall, out, 1, 1 while the current request is not complete.
REQ-015 Port mem_req, out, 1, memory request.
REQ-016 Port mem_we, out, 1, memory write.
REQ-017 Port mem_addr, out, DATA_WIDTH, word-aligned memory address.
REQ-018 Port mem_wdata, out, DATA_WIDTH, write data.
REQ-019 Port mem_wstrb, out, 4, byte enables.
REQ-020 Port mem_ack, in, 1, completes one beat; it is only meaningful while mem_req=1.
REQ-021 Port mem_rdata, in, DATA_WIDTH, read beat data; valid when mem_ack=1.
REQ-022 Port hit_count, out, 32, saturating count of completed hits.
REQ-023 Port miss_count, out, 32, saturating count of read misses.

Function
REQ-024 The FSM SHALL have exactly three states: IDLE, FILL and WRITE.
REQ-025 In IDLE, a hit is cpu_valid & valid[set] & (tag_store[set]==tag).
REQ-026 A load hit in IDLE SHALL return cpu_rdata combinationally in the same cycle, with cpu_stall=0 and no state change.
- The selected word is given by the word field.
- A byte load returns {24'b0, selected byte}, where the byte lane is addr[1:0].
REQ-027 A load miss in IDLE SHALL raise cpu_stall, go to FILL, clear the beat counter and increment miss_count.
REQ-028 In FILL, the controller SHALL hold mem_req=1 and mem_we=0, with mem_addr={tag, set, beat, 2'b00}.
- Each mem_ack writes mem_rdata into word[beat] of the line.
- Each mem_ack increments beat.
REQ-029 On the mem_ack of beat WORDS-1, the controller SHALL:
- set valid[set]=1 and tag_store[set]=tag;
- drop mem_req and return to IDLE.
- The retried lookup then hits, so a load miss takes WORDS acked beats plus 1 cycle.
REQ-030 The CPU SHALL hold all cpu_* inputs stable while cpu_stall=1; behaviour is undefined otherwise.
REQ-031 Stores SHALL be write-through and no-write-allocate.
- A store in IDLE goes to WRITE with cpu_stall=1.
REQ-032 In WRITE, the controller SHALL drive mem_req=1, mem_we=1 and mem_addr={addr[31:2], 2'b00}.
- mem_wdata is cpu_wdata for a word store, or the byte replicated to all four lanes for a byte store.
- mem_wstrb is 4'b1111 for a word store, or one-hot at addr[1:0] for a byte store.
REQ-033 On mem_ack in WRITE, the controller SHALL return to IDLE with cpu_stall=0 for that cycle.
- If the line was a hit, the cached word or byte is updated on the same edge.
- If the line missed, the cache is unchanged.
REQ-034 hit_count SHALL increment once per completed access that hit, including store hits counted on completion.
- A refill retry counts as a hit.
- Both counters saturate at 32'hFFFF_FFFF.
REQ-035 In IDLE, flush SHALL clear all valid bits on the next edge; a request in the same cycle is evaluated against the pre-flush state.
REQ-036 A flush in FILL or WRITE SHALL be latched and applied on the edge that returns to IDLE, after the fill update, leaving all lines invalid.
REQ-037 While mem_req=1 with no mem_ack, the controller SHALL hold all mem_* outputs stable, with no timeout.
REQ-038 Outside FILL and WRITE, mem_req, mem_we, mem_wstrb, mem_addr and mem_wdata SHALL be 0.

Reset
REQ-039 When rst_n=0, asynchronously and regardless of state, the block SHALL:
- set state to IDLE and beat to 0;
- clear all valid bits, both counters and the pending-flush bit;
- drive mem_req=0 and cpu_stall=0.
REQ-040 A fill interrupted by reset SHALL leave its line invalid.
- Data and tag arrays need not be reset.
REQ-041 After rst_n rises, the first lookup of any address SHALL miss.

Verification
REQ-042 With defaults after reset: load 0x0000_0040 -> 4 beats at mem_addr 0x40, 0x44, 0x48, 0x4C with rdata 0xA0..0xA3; cpu_rdata=0xA0 one cycle after the last ack; miss_count=1, hit_count=1.
REQ-043 Then byte load 0x0000_0049 with beat word 0x1122_3344 at 0x48 -> hit, cpu_rdata=0x0000_0033, no mem_req.
REQ-044 Byte store 0x55 to 0x4A with a 2-cycle ack delay -> mem_wstrb=4'b0100, mem_wdata=0x5555_5555, stall for 3 cycles; the following load of 0x48 hits with 0x1155_3344.
REQ-045 Load 0x0000_0140 (same set 0, different tag) -> miss and refill; then reload of 0x40 -> miss (line was evicted).
REQ-046 Flush during FILL beat 2 -> fill completes, the access returns data, and the next load of the same address misses.
REQ-047 rst_n low during FILL beat 1 -> mem_req=0 immediately; after release, a load of that address issues a full 4-beat fill.
